// File: rtl/pc_ifid_stage.sv
// -----------------------------------------------------------------------------
// pc_ifid_stage
//
// Fetch-side front end of a classic five-stage pipeline: the program counter
// register, its next-PC selection (sequential / branch / jump / hold), the
// IF/ID pipeline register, and two saturating event counters for hazard
// statistics.
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   rst            asynchronous active-high reset
//   PCWrite        1 = PC may advance, 0 = hold PC (load-use stall)
//   IF_ID_Write    1 = IF/ID may load, 0 = hold IF/ID contents
//   IF_Flush       squash the instruction currently being fetched
//   Branch_Taken   redirect PC to Branch_Target
//   Branch_Target  branch destination byte address
//   Jump           redirect PC to Jump_Target (wins over Branch_Taken)
//   Jump_Target    jump destination byte address
//   Instr_In       instruction word read combinationally at address PC
//   PC             current fetch address (registered)
//   IF_ID_PC4      PC+4 of the instruction held in IF/ID
//   IF_ID_Instr    instruction held in IF/ID
//   IF_ID_Valid    1 = IF/ID holds a real instruction, 0 = bubble
//   Stall_Count    cycles with PCWrite=0, saturating at 0xFFFF
//   Flush_Count    IF/ID flushes applied, saturating at 0xFFFF
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module pc_ifid_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        IF_Flush,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Jump,
  input  logic [31:0] Jump_Target,
  input  logic [31:0] Instr_In,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid,
  output logic [15:0] Stall_Count,
  output logic [15:0] Flush_Count
);

  // Source of the next fetch address, in priority order.
  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_JUMP   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_SEQ    = 2'd3
  } pc_sel_e;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc4: 32'h0, instr: 32'h0, valid: 1'b0};
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [31:0] pc_q;
  logic [31:0] pc4;
  logic [31:0] pc_d;
  pc_sel_e     pc_sel;

  if_id_t      if_id_q;
  if_id_t      if_id_d;

  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        stall_evt;
  logic        flush_evt;

  // 32-bit add wraps naturally: 0xFFFFFFFC + 4 = 0x00000000.
  assign pc4 = pc_q + 32'd4;

  // ---------------------------------------------------------------------------
  // Next-PC selection. A stall freezes the PC and silently drops any redirect
  // presented in the same cycle; the ID stage holds the branch/jump and
  // re-presents it once the stall clears. Targets are taken verbatim, with no
  // alignment masking.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    pc_sel = PC_SEQ;
    pc_d   = pc4;

    if (!PCWrite)          pc_sel = PC_HOLD;
    else if (Jump)         pc_sel = PC_JUMP;
    else if (Branch_Taken) pc_sel = PC_BRANCH;

    case (pc_sel)
      PC_HOLD:   pc_d = pc_q;
      PC_JUMP:   pc_d = Jump_Target;
      PC_BRANCH: pc_d = Branch_Target;
      default:   pc_d = pc4;
    endcase
  end

  // ---------------------------------------------------------------------------
  // IF/ID next state. A held register is never squashed: IF_ID_Write=0 wins
  // over IF_Flush, so the instruction stalled in ID survives and the flush is
  // not counted. PCWrite and IF_ID_Write are deliberately independent.
  // ---------------------------------------------------------------------------
  always_comb begin
    if_id_d = if_id_q;
    if (IF_ID_Write) begin
      if (IF_Flush) begin
        if_id_d = IF_ID_BUBBLE;
      end else begin
        if_id_d.pc4   = pc4;
        if_id_d.instr = Instr_In;
        if_id_d.valid = 1'b1;
      end
    end
  end

  assign stall_evt = !PCWrite;
  assign flush_evt = IF_ID_Write && IF_Flush;

  // ---------------------------------------------------------------------------
  // State registers. Reset is asynchronous and overrides every input, so a
  // reset arriving mid-stall or mid-flush simply discards that operation.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      pc_q        <= 32'h0;
      if_id_q     <= IF_ID_BUBBLE;
      stall_cnt_q <= 16'h0;
      flush_cnt_q <= 16'h0;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      if (stall_evt && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_evt && (flush_cnt_q != CNT_MAX)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign PC          = pc_q;
  assign IF_ID_PC4   = if_id_q.pc4;
  assign IF_ID_Instr = if_id_q.instr;
  assign IF_ID_Valid = if_id_q.valid;
  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;

endmodule

// File: tb/tb_pc_ifid_stage.sv
// -----------------------------------------------------------------------------
// tb_pc_ifid_stage
//
// Self-checking bench for pc_ifid_stage. A behavioural model of the fetch
// stage computes the expected register contents for every driven cycle and
// pushes them to a queue; after the clock edge the entry is popped and
// compared with the DUT outputs. Directed scenarios also check literal
// addresses, and a random phase exercises mixed hazards.
// -----------------------------------------------------------------------------
module tb_pc_ifid_stage;

  logic        clk;
  logic        rst;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_Flush;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Jump;
  logic [31:0] Jump_Target;
  logic [31:0] Instr_In;
  logic [31:0] PC;
  logic [31:0] IF_ID_PC4;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_Valid;
  logic [15:0] Stall_Count;
  logic [15:0] Flush_Count;

  pc_ifid_stage dut (
    .clk          (clk),
    .rst          (rst),
    .PCWrite      (PCWrite),
    .IF_ID_Write  (IF_ID_Write),
    .IF_Flush     (IF_Flush),
    .Branch_Taken (Branch_Taken),
    .Branch_Target(Branch_Target),
    .Jump         (Jump),
    .Jump_Target  (Jump_Target),
    .Instr_In     (Instr_In),
    .PC           (PC),
    .IF_ID_PC4    (IF_ID_PC4),
    .IF_ID_Instr  (IF_ID_Instr),
    .IF_ID_Valid  (IF_ID_Valid),
    .Stall_Count  (Stall_Count),
    .Flush_Count  (Flush_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Model state
  logic [31:0] m_pc;
  logic [31:0] m_pc4;
  logic [31:0] m_instr;
  logic        m_valid;
  logic [15:0] m_stall;
  logic [15:0] m_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, want);
    end
  endtask

  // Instruction memory contents: word at byte address a.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h20080001 + (a >> 2);
  endfunction

  task automatic model_reset();
    m_pc    = 32'h0;
    m_pc4   = 32'h0;
    m_instr = 32'h0;
    m_valid = 1'b0;
    m_stall = 16'h0;
    m_flush = 16'h0;
  endtask

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic model_edge();
    logic [31:0] nxt;
    if (!PCWrite)          nxt = m_pc;
    else if (Jump)         nxt = Jump_Target;
    else if (Branch_Taken) nxt = Branch_Target;
    else                   nxt = m_pc + 32'd4;
    if (IF_ID_Write) begin
      if (IF_Flush) begin
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        if (m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
      end else begin
        m_instr = imem(m_pc);
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
      end
    end
    if (!PCWrite && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    m_pc = nxt;
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".pc"},    PC,                 e.pc);
    check({tag, ".pc4"},   IF_ID_PC4,          e.pc4);
    check({tag, ".instr"}, IF_ID_Instr,        e.instr);
    check({tag, ".valid"}, {31'h0, IF_ID_Valid}, {31'h0, e.valid});
    check({tag, ".stall"}, {16'h0, Stall_Count}, {16'h0, e.stall});
    check({tag, ".flush"}, {16'h0, Flush_Count}, {16'h0, e.flush});
  endtask

  // Drive one cycle of stimulus, push the model's expectation, clock, then
  // pop and compare 1 time unit after the edge.
  task automatic step(input string tag,
                      input logic pcw, input logic ifw, input logic fl,
                      input logic bt, input logic [31:0] btgt,
                      input logic j, input logic [31:0] jtgt);
    exp_t e;
    PCWrite       = pcw;
    IF_ID_Write   = ifw;
    IF_Flush      = fl;
    Branch_Taken  = bt;
    Branch_Target = btgt;
    Jump          = j;
    Jump_Target   = jtgt;
    Instr_In      = imem(m_pc);
    model_edge();
    e = '{pc: m_pc, pc4: m_pc4, instr: m_instr, valid: m_valid, stall: m_stall, flush: m_flush};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".queue_empty"}, 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      check_all(tag, e);
    end
  endtask

  task automatic seq(input string tag);
    step(tag, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  exp_t zero_e;

  initial begin
    zero_e = '{pc: 32'h0, pc4: 32'h0, instr: 32'h0, valid: 1'b0, stall: 16'h0, flush: 16'h0};
    rst = 1'b1;
    PCWrite = 1'b1; IF_ID_Write = 1'b1; IF_Flush = 1'b0;
    Branch_Taken = 1'b0; Branch_Target = 32'h0;
    Jump = 1'b0; Jump_Target = 32'h0; Instr_In = imem(32'h0);
    model_reset();

    // Reset state, with inputs active across an edge while reset is held.
    Jump = 1'b1; Jump_Target = 32'h0000_0300; PCWrite = 1'b0; IF_Flush = 1'b1;
    #12;
    check_all("reset", zero_e);
    Jump = 1'b0; PCWrite = 1'b1; IF_Flush = 1'b0;
    rst = 1'b0;

    // First edge after reset and sequential fetch.
    seq("first");
    check("first.pc_lit", PC, 32'h4);
    check("first.instr_lit", IF_ID_Instr, 32'h20080001);
    seq("seq1");
    seq("seq2");
    seq("seq3");
    check("seq3.pc_lit", PC, 32'h10);
    check("seq3.pc4_lit", IF_ID_PC4, 32'h10);

    // Load-use stall, with a redirect that must be ignored.
    step("stall", 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h400);
    check("stall.pc_lit", PC, 32'h10);
    check("stall.cnt_lit", {16'h0, Stall_Count}, 32'h1);
    seq("resume");
    check("resume.pc_lit", PC, 32'h14);

    seq("seq4");
    seq("seq5");
    check("seq5.pc_lit", PC, 32'h1C);
    seq("seq6");
    check("seq6.pc_lit", PC, 32'h20);

    // Taken branch with flush.
    step("branch", 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    check("branch.pc_lit", PC, 32'h100);
    check("branch.valid_lit", {31'h0, IF_ID_Valid}, 32'h0);
    check("branch.flush_lit", {16'h0, Flush_Count}, 32'h1);
    seq("branch_tgt");
    check("branch_tgt.pc4_lit", IF_ID_PC4, 32'h104);
    check("branch_tgt.instr_lit", IF_ID_Instr, imem(32'h100));

    // Jump beats branch.
    step("jump_vs_br", 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200);
    check("jump_vs_br.pc_lit", PC, 32'h200);
    seq("jump_tgt");

    // Held IF/ID is not squashed and the flush is not counted.
    step("hold_vs_flush", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("hold_vs_flush.valid_lit", {31'h0, IF_ID_Valid}, 32'h1);
    check("hold_vs_flush.flush_lit", {16'h0, Flush_Count}, 32'h2);

    // Unmasked target and PC wrap.
    step("unaligned", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h203);
    check("unaligned.pc_lit", PC, 32'h203);
    step("to_top", 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    seq("wrap");
    check("wrap.pc_lit", PC, 32'h0);
    check("wrap.pc4_lit", IF_ID_PC4, 32'h0);

    // Random mixed hazards.
    for (int i = 0; i < 60; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 4) == 0),
           $urandom & 32'hFFFF_FFFC);
    end

    // Asynchronous reset pulsed between edges in the middle of a stall.
    step("pre_rst_stall", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", zero_e);
    rst = 1'b0;
    model_reset();
    seq("post_rst");
    check("post_rst.pc_lit", PC, 32'h4);

    // Stall counter saturation.
    PCWrite = 1'b0; IF_ID_Write = 1'b0; IF_Flush = 1'b0;
    Jump = 1'b0; Branch_Taken = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      Instr_In = imem(m_pc);
      model_edge();
      @(posedge clk);
    end
    #1;
    check("sat.stall_lit", {16'h0, Stall_Count}, 32'h0000_FFFF);
    check("sat.stall_model", {16'h0, Stall_Count}, {16'h0, m_stall});
    check("sat.pc_lit", PC, 32'h4);
    step("sat_more", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
